nor_bus_ctrl: RTL and testbench



---
 rtl/nor_bus_ctrl_if.sv | 36 +++
 rtl/nor_bus_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_nor_bus_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/nor_bus_ctrl_if.sv
// Pin bundle for nor_bus_ctrl: Wishbone pipelined slave port on one side,
// asynchronous parallel-NOR device pins on the other.
interface nor_bus_ctrl_if #(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16
);
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_we_i;
  logic [31:0]         wb_adr_i;
  logic [DATABITS-1:0] wb_dat_i;
  logic                wb_ack_o;
  logic                wb_err_o;
  logic                wb_stall_o;
  logic [DATABITS-1:0] wb_dat_o;
  logic [ADDRBITS-1:0] nor_addr_o;
  logic [DATABITS-1:0] nor_data_i;
  logic [DATABITS-1:0] nor_data_o;
  logic                nor_data_oe;
  logic                nor_ce_o;
  logic                nor_oe_o;
  logic                nor_we_o;
  logic                nor_ry_i;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, nor_data_i, nor_ry_i,
    output wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o,
           nor_addr_o, nor_data_o, nor_data_oe, nor_ce_o, nor_oe_o, nor_we_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, nor_data_i, nor_ry_i,
    input  wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o,
           nor_addr_o, nor_data_o, nor_data_oe, nor_ce_o, nor_oe_o, nor_we_o
  );
endinterface

// File: rtl/nor_bus_ctrl.sv
// Wishbone pipelined slave that runs single-word asynchronous NOR read and
// program cycles, with RY/BY# polling and all bus timing counted in clk_i cycles.
module nor_bus_ctrl #(
  parameter int ADDRBITS    = 26,
  parameter int DATABITS    = 16,
  parameter int RD_CYCLES   = 8,
  parameter int WR_SETUP    = 1,
  parameter int WR_PULSE    = 4,
  parameter int WR_HOLD     = 1,
  parameter int RECOVERY    = 2,
  parameter int RDY_TIMEOUT = 65535
) (
  input logic           clk_i,
  input logic           reset_i,
  nor_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_RECOVER
  } state_t;

  localparam logic [15:0] L_RD_LAST = 16'(RD_CYCLES - 1);
  localparam logic [15:0] L_SU_LAST = 16'(WR_SETUP - 1);
  localparam logic [15:0] L_PW_LAST = 16'(WR_PULSE - 1);
  localparam logic [15:0] L_HD_LAST = 16'(WR_HOLD - 1);
  localparam logic [15:0] L_RC_LAST = 16'(RECOVERY - 1);
  localparam logic [15:0] L_TO_LAST = 16'(RDY_TIMEOUT - 1);

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_cnt, w_cnt_nxt;
  logic [1:0]          r_ry_sync;
  logic                r_dir_wr, w_dir_wr_nxt;
  logic                r_live, w_live_nxt;
  logic                r_ce, w_ce_nxt;
  logic                r_oe, w_oe_nxt;
  logic                r_we, w_we_nxt;
  logic                r_doe, w_doe_nxt;
  logic [ADDRBITS-1:0] r_addr, w_addr_nxt;
  logic [DATABITS-1:0] r_wdata, w_wdata_nxt;
  logic [DATABITS-1:0] r_rdata, w_rdata_nxt;
  logic                r_ack, w_ack_nxt;
  logic                r_err, w_err_nxt;
  logic                w_ry_s, w_stall, w_accept, w_adr_ok, w_report;

  assign w_ry_s   = r_ry_sync[1];
  assign w_stall  = reset_i || (r_state != S_IDLE);
  assign w_accept = bus.wb_cyc_i && bus.wb_stb_i && !w_stall;
  assign w_adr_ok = (bus.wb_adr_i[31:ADDRBITS] == '0);
  // Completion is reported only if the master kept the cycle open throughout.
  assign w_report = r_live && bus.wb_cyc_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_ry_sync <= 2'b00;
    else         r_ry_sync <= {r_ry_sync[0], bus.nor_ry_i};
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dir_wr_nxt = r_dir_wr;
    w_live_nxt   = r_live && bus.wb_cyc_i;
    w_ce_nxt     = r_ce;
    w_oe_nxt     = r_oe;
    w_we_nxt     = r_we;
    w_doe_nxt    = r_doe;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rdata_nxt  = r_rdata;
    w_ack_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_dir_wr_nxt = bus.wb_we_i;
          w_wdata_nxt  = bus.wb_dat_i;
          w_live_nxt   = 1'b1;
          w_cnt_nxt    = '0;
          if (w_adr_ok) begin
            w_addr_nxt  = bus.wb_adr_i[ADDRBITS-1:0];
            w_ce_nxt    = 1'b0;
            w_state_nxt = S_WAIT_RDY;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_RECOVER;
          end
        end
      end
      S_WAIT_RDY: begin
        if (w_ry_s) begin
          w_cnt_nxt = '0;
          if (r_dir_wr) begin
            w_doe_nxt   = 1'b1;
            w_state_nxt = S_WR_SETUP;
          end else begin
            w_oe_nxt    = 1'b0;
            w_state_nxt = S_RD;
          end
        end else if (r_cnt == L_TO_LAST) begin
          w_ce_nxt    = 1'b1;
          w_err_nxt   = w_report;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RECOVER;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_RD: begin
        if (r_cnt == L_RD_LAST) begin
          w_rdata_nxt = bus.nor_data_i;
          w_oe_nxt    = 1'b1;
          w_ce_nxt    = 1'b1;
          w_ack_nxt   = w_report;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RECOVER;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_WR_SETUP: begin
        if (r_cnt == L_SU_LAST) begin
          w_we_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WR_PULSE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_WR_PULSE: begin
        if (r_cnt == L_PW_LAST) begin
          w_we_nxt    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_WR_HOLD: begin
        if (r_cnt == L_HD_LAST) begin
          w_ce_nxt    = 1'b1;
          w_doe_nxt   = 1'b0;
          w_ack_nxt   = w_report;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RECOVER;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_RECOVER: begin
        if (r_cnt == L_RC_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dir_wr <= 1'b0;
      r_live   <= 1'b0;
      r_ce     <= 1'b1;
      r_oe     <= 1'b1;
      r_we     <= 1'b1;
      r_doe    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir_wr <= w_dir_wr_nxt;
      r_live   <= w_live_nxt;
      r_ce     <= w_ce_nxt;
      r_oe     <= w_oe_nxt;
      r_we     <= w_we_nxt;
      r_doe    <= w_doe_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rdata  <= w_rdata_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign bus.wb_ack_o    = r_ack;
  assign bus.wb_err_o    = r_err;
  assign bus.wb_stall_o  = w_stall;
  assign bus.wb_dat_o    = r_rdata;
  assign bus.nor_addr_o  = r_addr;
  assign bus.nor_data_o  = r_wdata;
  assign bus.nor_data_oe = r_doe;
  assign bus.nor_ce_o    = r_ce;
  assign bus.nor_oe_o    = r_oe;
  assign bus.nor_we_o    = r_we;

endmodule

// File: tb/tb_nor_bus_ctrl.sv
// Randomized bench for nor_bus_ctrl: a pin-level NOR device, a monitor that
// tallies strobe activity, and a transaction-level timing/data reference model.
module tb_nor_bus_ctrl;
  localparam int AB  = 26;
  localparam int DB  = 16;
  localparam int RDC = 8;
  localparam int WS  = 1;
  localparam int WP  = 4;
  localparam int WH  = 1;
  localparam int REC = 2;
  localparam int TMO = 20;

  logic clk_i = 1'b0;
  logic reset_i;

  nor_bus_ctrl_if #(.ADDRBITS(AB), .DATABITS(DB)) bus ();

  nor_bus_ctrl #(
    .ADDRBITS(AB), .DATABITS(DB), .RD_CYCLES(RDC), .WR_SETUP(WS),
    .WR_PULSE(WP), .WR_HOLD(WH), .RECOVERY(REC), .RDY_TIMEOUT(TMO)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n    = 0;

  // Monitor tallies, written only by the monitor process.
  int n_ack = 0, n_err = 0, n_oe = 0, n_we = 0, n_doe = 0, n_ce = 0;
  int n_viol = 0, n_stab = 0, ack_at = 0, err_at = 0, busy_at = 0;
  logic [DB-1:0] ack_dat;
  logic          prev_we = 1'b1;
  logic [DB-1:0] dev_mem [logic [AB-1:0]];

  // Expected pin values while WE is low, and the reference memory image.
  logic [AB-1:0] exp_addr = '0;
  logic [DB-1:0] exp_data = '0;
  logic [DB-1:0] ref_mem [logic [AB-1:0]];

  // Unwritten device locations read as this fill; address 0x1234 reads 0xBEEF.
  function automatic logic [DB-1:0] pat(input logic [AB-1:0] a);
    return a[15:0] ^ 16'hACDB;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  always @(negedge clk_i) begin
    if (bus.wb_ack_o) begin n_ack++; ack_at = cyc_n; ack_dat = bus.wb_dat_o; end
    if (bus.wb_err_o) begin n_err++; err_at = cyc_n; end
    if (bus.wb_ack_o && bus.wb_err_o) n_viol++;
    if (!bus.nor_oe_o) begin
      n_oe++;
      if (!bus.nor_we_o || bus.nor_data_oe) n_viol++;
    end
    if (!bus.nor_we_o) begin
      n_we++;
      if (bus.nor_addr_o != exp_addr || bus.nor_data_o != exp_data ||
          !bus.nor_data_oe || bus.nor_ce_o) n_stab++;
    end
    if (bus.nor_data_oe) n_doe++;
    if (!bus.nor_ce_o) n_ce++;
    if (bus.wb_stall_o) busy_at = cyc_n;
    if (!prev_we && bus.nor_we_o && !bus.nor_ce_o) dev_mem[bus.nor_addr_o] = bus.nor_data_o;
    prev_we = bus.nor_we_o;
    bus.nor_data_i = dev_mem.exists(bus.nor_addr_o) ? dev_mem[bus.nor_addr_o] : pat(bus.nor_addr_o);
  end

  // ry_k: 0 = device ready; k>0 = RY low, released just after edge accept+k-1.
  // drop_at: 0 = keep cyc; d>0 = drop cyc just after edge accept+d.
  task automatic run_txn(input bit wr, input logic [31:0] adr, input logic [DB-1:0] dat,
                         input int ry_k, input int drop_at);
    int e0, extra, body, c, guard;
    int a_ack, a_err, a_oe, a_we, a_doe, a_ce, a_viol, a_stab;
    bit oob, tmo, ok, dropped;
    logic [DB-1:0] exp_rd;
    logic [AB-1:0] a;
    @(negedge clk_i);
    guard = 0;
    while (bus.wb_stall_o && guard < 100) begin @(negedge clk_i); guard++; end
    chk("idle_wait", 32'(bus.wb_stall_o), 0);
    bus.nor_ry_i = (ry_k == 0);
    repeat (3) @(negedge clk_i);
    a      = adr[AB-1:0];
    oob    = (adr[31:AB] != '0);
    exp_rd = ref_mem.exists(a) ? ref_mem[a] : pat(a);
    a_ack = n_ack; a_err = n_err; a_oe = n_oe; a_we = n_we;
    a_doe = n_doe; a_ce = n_ce; a_viol = n_viol; a_stab = n_stab;
    exp_addr = a; exp_data = dat;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = wr;
    bus.wb_adr_i = adr;  bus.wb_dat_i = dat;
    @(posedge clk_i); #1;
    e0 = cyc_n;
    bus.wb_stb_i = 1'b0;
    extra   = (ry_k > 0) ? ry_k + 1 : 0;
    body    = wr ? (WS + WP + WH) : RDC;
    tmo     = !oob && (extra >= TMO);
    ok      = !oob && !tmo;
    c       = oob ? e0 : (tmo ? e0 + TMO : e0 + 1 + extra + body);
    dropped = (drop_at > 0) && (drop_at <= c - e0 - 1);
    while (cyc_n < c + REC + 2) begin
      if (ry_k > 0 && cyc_n == e0 + ry_k - 1) bus.nor_ry_i = 1'b1;
      if (drop_at > 0 && cyc_n == e0 + drop_at) bus.wb_cyc_i = 1'b0;
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    bus.wb_cyc_i = 1'b0;
    bus.nor_ry_i = 1'b1;
    chk("ack_cnt", n_ack - a_ack, (ok && !dropped) ? 1 : 0);
    chk("err_cnt", n_err - a_err, (!ok && !dropped) ? 1 : 0);
    if (ok && !dropped) chk("ack_at", ack_at - e0, c - e0);
    if (ok && !dropped && !wr) chk("rd_data", 32'(ack_dat), 32'(exp_rd));
    if (!ok && !dropped) chk("err_at", err_at - e0, c - e0);
    chk("oe_low", n_oe - a_oe, (ok && !wr) ? RDC : 0);
    chk("we_low", n_we - a_we, (ok && wr) ? WP : 0);
    chk("doe_hi", n_doe - a_doe, (ok && wr) ? body : 0);
    chk("ce_low", n_ce - a_ce, oob ? 0 : (tmo ? TMO : 1 + extra + body));
    chk("proto", n_viol - a_viol, 0);
    chk("we_stable", n_stab - a_stab, 0);
    chk("busy_end", busy_at - e0, c + REC - 1 - e0);
    if (ok && wr) ref_mem[a] = dat;
  endtask

  initial begin
    int a_ack, a_err;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.nor_ry_i = 1'b1;
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ce", 32'(bus.nor_ce_o), 1);
    chk("rst_oe", 32'(bus.nor_oe_o), 1);
    chk("rst_we", 32'(bus.nor_we_o), 1);
    chk("rst_doe", 32'(bus.nor_data_oe), 0);
    chk("rst_addr", 32'(bus.nor_addr_o), 0);
    chk("rst_wdata", 32'(bus.nor_data_o), 0);
    chk("rst_rdata", 32'(bus.wb_dat_o), 0);
    chk("rst_ack", 32'(bus.wb_ack_o), 0);
    chk("rst_err", 32'(bus.wb_err_o), 0);
    chk("rst_stall", 32'(bus.wb_stall_o), 1);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("stall_idle", 32'(bus.wb_stall_o), 0);

    run_txn(1'b0, 32'h0000_1234, 16'h0000, 0, 0);
    run_txn(1'b1, 32'h03FF_FFFF, 16'h5A5A, 0, 0);
    run_txn(1'b0, 32'h03FF_FFFF, 16'h0000, 0, 0);
    run_txn(1'b0, 32'h0400_0000, 16'h0000, 0, 0);
    run_txn(1'b0, 32'h0000_0005, 16'h0000, 4, 0);
    run_txn(1'b0, 32'h0000_0006, 16'h0000, 30, 0);
    run_txn(1'b0, 32'h0000_0006, 16'h0000, 18, 0);
    run_txn(1'b0, 32'h0000_0006, 16'h0000, 19, 0);
    run_txn(1'b1, 32'h0000_0002, 16'h1357, 0, 3);
    run_txn(1'b0, 32'h0000_0002, 16'h0000, 0, 0);

    // Reset asserted while WE is low.
    @(negedge clk_i);
    exp_addr = 26'h200_0000; exp_data = 16'hC3C3;
    a_ack = n_ack; a_err = n_err;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 32'h0200_0000; bus.wb_dat_i = 16'hC3C3;
    @(posedge clk_i); #1;
    bus.wb_stb_i = 1'b0;
    for (int i = 0; i < 20 && bus.nor_we_o; i++) @(negedge clk_i);
    chk("rst_pulse_seen", 32'(bus.nor_we_o), 0);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_mid_we", 32'(bus.nor_we_o), 1);
    chk("rst_mid_ce", 32'(bus.nor_ce_o), 1);
    chk("rst_mid_oe", 32'(bus.nor_oe_o), 1);
    chk("rst_mid_doe", 32'(bus.nor_data_oe), 0);
    reset_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("rst_mid_noack", n_ack - a_ack, 0);
    chk("rst_mid_noerr", n_err - a_err, 0);

    for (int t = 0; t < 40; t++) begin
      int sel, rk, dr;
      logic [31:0] ad;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      ad = 32'($urandom_range(0, 7));
      else if (sel == 7) ad = 32'h03FF_FFFF;
      else if (sel == 8) ad = 32'h0400_0000 | 32'($urandom_range(0, 255));
      else               ad = 32'h8000_0000;
      sel = $urandom_range(0, 9);
      if (sel < 6)      rk = 0;
      else if (sel < 9) rk = $urandom_range(1, 5);
      else              rk = $urandom_range(18, 22);
      dr = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      run_txn(1'($urandom_range(0, 1)), ad, 16'($urandom), rk, dr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
